// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide execute unit.
// One multiplier bit (shift-add) or one quotient bit (restoring division)
// is produced per clock. The selected result is handed to the register
// file as a registered write that is held until the writeback port is ready.
module muldiv_unit #(
  parameter int W = 32,
  parameter int B = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [B-1:0] dest_i,
  input  logic         wb_ready_i,
  output logic         busy_o,
  output logic         wen_o,
  output logic [B-1:0] wa_o,
  output logic [W-1:0] wd_o
);

  // Counter must hold the value W itself, hence W+1 distinct values.
  localparam int CW = $clog2(W + 1);

  // Operation encodings. Bit 1 distinguishes divide ops from multiply ops.
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t         state_reg;
  logic [1:0]     op_reg;
  logic [B-1:0]   dest_reg;
  logic [CW-1:0]  cnt_reg;

  // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
  logic [W-1:0]   opnd_reg;

  // Multiply datapath: upper half accumulates, lower half holds the
  // not-yet-consumed multiplier bits (shifted out LSB first).
  logic [2*W-1:0] prod_reg;

  // Divide datapath: partial remainder and the dividend register, which is
  // shifted left as quotient bits are inserted from the right.
  logic [W-1:0]   rem_reg;
  logic [W-1:0]   quo_reg;

  // Registered writeback outputs.
  logic           busy_reg;
  logic           wen_reg;
  logic [B-1:0]   wa_reg;
  logic [W-1:0]   wd_reg;

  // Next-step values of the iterative datapaths.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod_next;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   result;

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole product right by one (the carry lands in bit 2W-1).
  always_comb begin
    mul_sum   = {1'b0, prod_reg[2*W-1:W]}
              + (prod_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
    prod_next = {mul_sum, prod_reg[W-1:1]};
  end

  // Restoring division step: bring down the next dividend bit, trial
  // subtract the divisor, keep the difference only if it did not borrow.
  // Since the partial remainder is always below the divisor, the shifted
  // value is below twice the divisor and the kept difference fits in W bits.
  // A zero divisor never borrows, so the quotient fills with ones and the
  // remainder ends up equal to the dividend without any special casing.
  always_comb begin
    div_shift = {rem_reg, quo_reg[W-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (div_diff[W]) begin
      rem_next = div_shift[W-1:0];
      quo_next = {quo_reg[W-2:0], 1'b0};
    end else begin
      rem_next = div_diff[W-1:0];
      quo_next = {quo_reg[W-2:0], 1'b1};
    end
  end

  // Pick the architectural result for the latched operation.
  always_comb begin
    result = rem_reg;
    case (op_reg)
      OP_MUL:   result = prod_reg[W-1:0];
      OP_MULHU: result = prod_reg[2*W-1:W];
      OP_DIVU:  result = quo_reg;
      default:  result = rem_reg;
    endcase
  end

  // Control FSM with registered outputs; also sequences both datapaths.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      dest_reg  <= '0;
      cnt_reg   <= '0;
      opnd_reg  <= '0;
      prod_reg  <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      busy_reg  <= 1'b0;
      wen_reg   <= 1'b0;
      wa_reg    <= '0;
      wd_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            op_reg   <= op_i;
            dest_reg <= dest_i;
            cnt_reg  <= CW'(W);
            rem_reg  <= '0;
            busy_reg <= 1'b1;
            state_reg <= S_RUN;
            if (op_i[1]) begin
              // Divide: dividend shifts out of quo_reg MSB first.
              opnd_reg <= b_i;
              quo_reg  <= a_i;
              prod_reg <= '0;
            end else begin
              // Multiply: multiplier sits in the low half, consumed LSB first.
              opnd_reg <= a_i;
              prod_reg <= {{W{1'b0}}, b_i};
              quo_reg  <= '0;
            end
          end
        end

        S_RUN: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
            if (op_reg[1]) begin
              rem_reg <= rem_next;
              quo_reg <= quo_next;
            end else begin
              prod_reg <= prod_next;
            end
          end else begin
            // All W iterations are in; publish the write.
            wen_reg   <= 1'b1;
            wa_reg    <= dest_reg;
            wd_reg    <= result;
            state_reg <= S_DONE;
          end
        end

        S_DONE: begin
          // Hold the write until accepted; clear it so nothing leaks while idle.
          if (wb_ready_i) begin
            wen_reg   <= 1'b0;
            wa_reg    <= '0;
            wd_reg    <= '0;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          wen_reg   <= 1'b0;
          wa_reg    <= '0;
          wd_reg    <= '0;
        end
      endcase
    end
  end

  assign busy_o = busy_reg;
  assign wen_o  = wen_reg;
  assign wa_o   = wa_reg;
  assign wd_o   = wd_reg;

endmodule
